// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing the world-map BRAM port between the DDA ray FSMs
// and the map-write client; reads are tagged so data returns only to its requester.
module map_port_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_REQ-1:0]        data_valid_out,
  input  logic                      wr_en_in,
  input  logic [ADDR_W-1:0]         wr_addr_in,
  input  logic [DATA_W-1:0]         wr_data_in,
  output logic                      wr_ack_out,
  output logic [ADDR_W-1:0]         ram_addr_out,
  output logic [DATA_W-1:0]         ram_din_out,
  output logic                      ram_we_out,
  input  logic [DATA_W-1:0]         ram_data_in,
  output logic                      busy_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = RAM_LATENCY + 1;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [DEPTH-1:0]   tag_v;
  logic [IDX_W-1:0]   tag_idx [DEPTH];

  // A requester whose data is returning this cycle may already be re-granted.
  always_comb eligible = req_in & ~(pending & ~data_valid_out);

  always_comb busy_out = |pending;

  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    gnt_nxt   = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(rr) + off) % NUM_REQ;
      if (!win_found && eligible[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
    if (!wr_en_in && win_found) gnt_nxt[win_idx] = 1'b1;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending        <= '0;
      rr             <= IDX_W'(NUM_REQ - 1);
      gnt_out        <= '0;
      data_out       <= '0;
      data_valid_out <= '0;
      wr_ack_out     <= 1'b0;
      ram_addr_out   <= '0;
      ram_din_out    <= '0;
      ram_we_out     <= 1'b0;
      tag_v          <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) tag_idx[s] <= '0;
    end else begin
      wr_ack_out <= wr_en_in;
      ram_we_out <= wr_en_in;
      gnt_out    <= gnt_nxt;
      if (wr_en_in) begin
        ram_addr_out <= wr_addr_in;
        ram_din_out  <= wr_data_in;
      end else if (win_found) begin
        ram_addr_out <= addr_in[win_idx*ADDR_W +: ADDR_W];
        rr           <= win_idx;
      end
      pending <= (pending & ~data_valid_out) | gnt_nxt;

      // Tag pipeline tracks the issued slot until its RAM data arrives.
      tag_v[0]   <= |gnt_nxt;
      tag_idx[0] <= win_idx;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end

      data_valid_out <= '0;
      if (tag_v[DEPTH-1]) begin
        data_valid_out[tag_idx[DEPTH-1]] <= 1'b1;
        data_out                         <= ram_data_in;
      end
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a read-first BRAM model (latency 2 and 1 builds).
module tb_map_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [19:0] addr;
  logic [1:0]  gnt, dvalid;
  logic [3:0]  dout;
  logic        wr_en, wr_ack, ram_we, busy;
  logic [9:0]  wr_addr, ram_addr;
  logic [3:0]  wr_data, ram_din, rd0, rd1;

  logic [1:0]  l1_req, l1_gnt, l1_dvalid;
  logic [19:0] l1_addr;
  logic [3:0]  l1_dout, l1_wr_data, l1_ram_din, l1_rd0;
  logic        l1_wr_en, l1_wr_ack, l1_ram_we, l1_busy;
  logic [9:0]  l1_wr_addr, l1_ram_addr;

  logic [3:0]  mem [1024];

  int checks = 0;
  int errors = 0;
  int n0, n1;
  int exp_g, exp_v;

  always #5 clk = ~clk;

  map_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(4), .RAM_LATENCY(2)) u_dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .req_in(req), .addr_in(addr),
    .gnt_out(gnt), .data_out(dout), .data_valid_out(dvalid),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_ack_out(wr_ack),
    .ram_addr_out(ram_addr), .ram_din_out(ram_din), .ram_we_out(ram_we),
    .ram_data_in(rd1), .busy_out(busy)
  );

  map_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(4), .RAM_LATENCY(1)) u_dut_l1 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .req_in(l1_req), .addr_in(l1_addr),
    .gnt_out(l1_gnt), .data_out(l1_dout), .data_valid_out(l1_dvalid),
    .wr_en_in(l1_wr_en), .wr_addr_in(l1_wr_addr), .wr_data_in(l1_wr_data), .wr_ack_out(l1_wr_ack),
    .ram_addr_out(l1_ram_addr), .ram_din_out(l1_ram_din), .ram_we_out(l1_ram_we),
    .ram_data_in(l1_rd0), .busy_out(l1_busy)
  );

  // Read-first single-port RAM; the latency-1 build only reads.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rd0    <= mem[ram_addr];
    rd1    <= rd0;
    l1_rd0 <= mem[l1_ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"},    32'(gnt), 0);
    chk({tag, " valid"},  32'(dvalid), 0);
    chk({tag, " data"},   32'(dout), 0);
    chk({tag, " wr_ack"}, 32'(wr_ack), 0);
    chk({tag, " ram_we"}, 32'(ram_we), 0);
    chk({tag, " ram_ad"}, 32'(ram_addr), 0);
    chk({tag, " ram_di"}, 32'(ram_din), 0);
    chk({tag, " busy"},   32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 4'h0;
    mem[37] <= 4'h5;
    mem[1]  <= 4'h7;
    mem[2]  <= 4'hA;
    mem[5]  <= 4'h3;
    rst_n = 1'b0;
    req = '0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    l1_req = '0; l1_addr = '0; l1_wr_en = 1'b0; l1_wr_addr = '0; l1_wr_data = '0;
    #2;
    chk_zero("reset");
    chk("reset l1 gnt", 32'(l1_gnt), 0);
    step(); step();
    rst_n = 1'b1;

    // Single read
    req = 2'b01; addr[9:0] = 10'd37;
    step();
    chk("sr gnt", 32'(gnt), 1);
    chk("sr ram_addr", 32'(ram_addr), 37);
    chk("sr ram_we", 32'(ram_we), 0);
    chk("sr busy1", 32'(busy), 1);
    step();
    chk("sr gnt pulse", 32'(gnt), 0);
    chk("sr busy2", 32'(busy), 1);
    step();
    chk("sr valid early", 32'(dvalid), 0);
    chk("sr busy3", 32'(busy), 1);
    step();
    chk("sr valid", 32'(dvalid), 1);
    chk("sr data", 32'(dout), 5);
    chk("sr busy4", 32'(busy), 1);
    req = 2'b00;
    step();
    chk("sr valid pulse", 32'(dvalid), 0);
    chk("sr busy end", 32'(busy), 0);
    chk("sr no regrant", 32'(gnt), 0);

    // Contention: rr last granted 0, so requester 1 leads
    req = 2'b11; addr[9:0] = 10'd1; addr[19:10] = 10'd2;
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 81; k++) begin
      step();
      exp_g = (k % 4 == 1 && k < 81) ? 2 : (k % 4 == 2) ? 1 : 0;
      exp_v = (k % 4 == 0) ? 2 : ((k % 4 == 1 && k > 1) ? 1 : 0);
      chk($sformatf("ctn%0d gnt", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("ctn%0d valid", k), 32'(dvalid), 32'(exp_v));
      if (exp_v != 0) chk($sformatf("ctn%0d data", k), 32'(dout), (exp_v == 2) ? 32'hA : 32'h7);
      if (dvalid[0]) n0++;
      if (dvalid[1]) n1++;
      if (k == 80) req = 2'b01;
      if (k == 81) req = 2'b00;
    end
    chk("ctn count0", 32'(n0), 20);
    chk("ctn count1", 32'(n1), 20);
    step();
    chk("ctn idle gnt", 32'(gnt), 0);
    chk("ctn idle busy", 32'(busy), 0);

    // Write priority over a same-cycle read to the same address
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 4'h9;
    req = 2'b10; addr[19:10] = 10'd2;
    step();
    chk("wp ack", 32'(wr_ack), 1);
    chk("wp ram_we", 32'(ram_we), 1);
    chk("wp ram_addr", 32'(ram_addr), 2);
    chk("wp ram_din", 32'(ram_din), 9);
    chk("wp no gnt", 32'(gnt), 0);
    wr_en = 1'b0;
    step();
    chk("wp ack pulse", 32'(wr_ack), 0);
    chk("wp gnt", 32'(gnt), 2);
    chk("wp ram_we off", 32'(ram_we), 0);
    step(); step(); step();
    chk("wp valid", 32'(dvalid), 2);
    chk("wp data", 32'(dout), 9);
    req = 2'b00;
    step();
    chk("wp busy end", 32'(busy), 0);

    // Read-first hazard: write issued the cycle after the read
    req = 2'b01; addr[9:0] = 10'd5;
    step();
    chk("hz gnt", 32'(gnt), 1);
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 4'hC;
    step();
    chk("hz ack", 32'(wr_ack), 1);
    wr_en = 1'b0;
    step(); step();
    chk("hz valid old", 32'(dvalid), 1);
    chk("hz data old", 32'(dout), 3);
    step();
    chk("hz regrant", 32'(gnt), 1);
    step(); step(); step();
    chk("hz valid new", 32'(dvalid), 1);
    chk("hz data new", 32'(dout), 12);
    req = 2'b00;
    step();
    chk("hz busy end", 32'(busy), 0);

    // Asynchronous reset with a read in flight
    req = 2'b10; addr[19:10] = 10'd1;
    step();
    chk("rs gnt before", 32'(gnt), 2);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("rs async");
    req = 2'b11; addr[9:0] = 10'd37;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rs hold%0d valid", k), 32'(dvalid), 0);
      chk($sformatf("rs hold%0d gnt", k), 32'(gnt), 0);
    end
    rst_n = 1'b1;
    step();
    chk("rs first gnt", 32'(gnt), 1);
    chk("rs stale1", 32'(dvalid), 0);
    step();
    chk("rs second gnt", 32'(gnt), 2);
    chk("rs stale2", 32'(dvalid), 0);
    step();
    chk("rs stale3", 32'(dvalid), 0);
    step();
    chk("rs valid0", 32'(dvalid), 1);
    chk("rs data0", 32'(dout), 5);
    req = 2'b10;
    step();
    chk("rs valid1", 32'(dvalid), 2);
    chk("rs data1", 32'(dout), 7);
    chk("rs gnt none", 32'(gnt), 0);
    req = 2'b00;
    step();
    chk("rs busy end", 32'(busy), 0);

    // Latency-1 build
    l1_req = 2'b01; l1_addr[9:0] = 10'd37;
    step();
    chk("l1 gnt", 32'(l1_gnt), 1);
    chk("l1 ram_addr", 32'(l1_ram_addr), 37);
    step();
    chk("l1 valid early", 32'(l1_dvalid), 0);
    step();
    chk("l1 valid", 32'(l1_dvalid), 1);
    chk("l1 data", 32'(l1_dout), 5);
    l1_req = 2'b00;
    step();
    chk("l1 valid pulse", 32'(l1_dvalid), 0);
    chk("l1 busy end", 32'(l1_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
- Pipelined round-robin arbiter that shares the single port of the 2D world-map BRAM between NUM_REQ DDA ray FSMs and one map-write client (map editor / level loader).
- Issues at most one BRAM access per cycle and tags every read so its data returns only to the FSM that requested it.
- Sits between the dda_fsm instances and the worldMap single-port read-first RAM, replacing per-access IDLE/GRANT/ASSIGN sequencing with a back-to-back pipeline.

Parameters:
- NUM_REQ, 2, number of read requesters (1..8).
- ADDR_W, 10, map address width (>= clog2(N*N) for a 24x24 map).
- DATA_W, 4, map cell width.
- RAM_LATENCY, 2, cycles from ram_addr_out to valid ram_data_in (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY).

Ports:
- pixel_clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- req_in  in  NUM_REQ  per-FSM read request, level.
- addr_in  in  NUM_REQ*ADDR_W  packed read addresses; requester i uses [i*ADDR_W +: ADDR_W].
- gnt_out  out  NUM_REQ  one-cycle grant pulse, one-hot or zero.
- data_out  out  DATA_W  read data, shared by all requesters.
- data_valid_out  out  NUM_REQ  one-cycle pulse marking data_out for requester i.
- wr_en_in  in  1  write request, level.
- wr_addr_in  in  ADDR_W  write address.
- wr_data_in  in  DATA_W  write data.
- wr_ack_out  out  1  one-cycle pulse; write issued to the RAM.
- ram_addr_out  out  ADDR_W  BRAM address.
- ram_din_out  out  DATA_W  BRAM write data.
- ram_we_out  out  1  BRAM write enable.
- ram_data_in  in  DATA_W  BRAM douta.
- busy_out  out  1  high while any read is in flight.

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0; pending bits, tag pipeline and valid pipeline cleared; rr pointer = NUM_REQ-1, so requester 0 wins first. In-flight reads are dropped and no data_valid_out pulses for them after reset.
- Eligibility:
  - Requester i is eligible when req_in[i] && !pending[i].
  - pending[i] sets on gnt_out[i] and clears in the data_valid_out[i] cycle, so i is eligible again the next cycle.
  - At most one outstanding read per requester.
- Requester contract:
  - Hold req_in[i] and its address stable from assertion until data_valid_out[i].
  - Drop req_in[i] or present a new address in the cycle after data_valid_out[i].
- Issue stage (registered): on each edge, one slot is selected.
  - (a) If wr_en_in is high, the write wins. Registers ram_addr_out=wr_addr_in, ram_din_out=wr_data_in, ram_we_out=1, wr_ack_out=1. No read grant in that cycle.
  - (b) Else, the first eligible requester searching from rr+1 modulo NUM_REQ wins. Registers ram_addr_out=its addr, ram_we_out=0, gnt_out[i]=1, rr=i.
  - (c) Else ram_we_out=0, gnt_out=0, and ram_addr_out holds its value.
- Write requester contract: hold wr_en_in and its data until wr_ack_out, then deassert the next cycle. A write held for consecutive cycles issues each cycle; this is the client's responsibility.
- Writes have absolute priority. Sustained wr_en_in starves reads, by design: the loader only runs outside frame rendering.
- Latency:
  - gnt_out[i] is asserted 1 cycle after the eligible req_in edge.
  - data_valid_out[i] and data_out are registered and asserted RAM_LATENCY+1 cycles after gnt_out[i].
  - With defaults: req sampled at edge T, gnt at T+1, valid at T+4.
- Tag pipeline: a shift register of depth RAM_LATENCY+1 carries {valid, requester index}. Writes insert valid=0. Throughput is one read per cycle.
- Hazard: the RAM is read-first. A read issued in the same cycle as a write to the same address returns old data. Reads issued after wr_ack_out return new data.
- busy_out = OR of the pending bits.
- Simultaneous events: grant and data_valid_out for different requesters in the same cycle are allowed. A requester can receive data_valid_out and be re-granted 1 cycle later, never in the same cycle.

Test Plan:
- Single read: req_in=01, addr0=37, RAM[37]=5 -> gnt_out=01 at T+1, data_valid_out=01 and data_out=5 at T+4, busy_out high T+1..T+4.
- Contention: req_in=11 held, addr0=1, addr1=2 -> grants alternate 01,10 on consecutive cycles, each re-grant RAM_LATENCY+2 cycles after the previous one, data routed to the correct requester over 20 reads each, no pulse lost.
- Write priority: wr_en_in with addr 2, data 9, plus req_in=10 for addr 2 in the same cycle -> wr_ack_out at T+1, gnt_out=10 at T+2, data_out=9.
- Same-cycle hazard: read granted at T+1 to addr 5 (old value 3), write to 5 issued at T+2 -> read returns 3; the next read returns the new value.
- Async reset mid-flight: rst_n_in low 1 ns after a grant, released 3 cycles later -> all outputs 0 immediately, no stale data_valid_out after release, requester 0 granted first.
- RAM_LATENCY=1 build: single read -> data_valid_out exactly 2 cycles after gnt_out.
